// File: rtl/next_pc_unit_if.sv
// Fetch/resolve bus between the pipeline and the next-PC unit.
// The master side is the pipeline (drives PC, instruction and EX resolution);
// the slave side is the next-PC unit (returns the next fetch address,
// prediction, flush request and statistics).
interface next_pc_unit_if;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic        pc_write_i;
    logic        res_valid_i;
    logic [31:0] res_pc_i;
    logic        res_taken_i;
    logic [31:0] res_target_i;
    logic        res_pred_i;
    logic [31:0] pc_next_o;
    logic        pred_taken_o;
    logic        flush_o;
    logic [15:0] br_cnt_o;
    logic [15:0] mis_cnt_o;

    modport master (
        output pc_i, instr_i, pc_write_i,
        output res_valid_i, res_pc_i, res_taken_i, res_target_i, res_pred_i,
        input  pc_next_o, pred_taken_o, flush_o, br_cnt_o, mis_cnt_o
    );

    modport slave (
        input  pc_i, instr_i, pc_write_i,
        input  res_valid_i, res_pc_i, res_taken_i, res_target_i, res_pred_i,
        output pc_next_o, pred_taken_o, flush_o, br_cnt_o, mis_cnt_o
    );
endinterface

// File: rtl/next_pc_unit.sv
// Next fetch address generator with a 2-bit saturating-counter branch
// history table, mispredict redirect and saturating branch statistics.
module next_pc_unit #(
    parameter int          BHT_IDX_W    = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input logic           clk_i,
    input logic           rst_i,
    next_pc_unit_if.slave bus
);
    localparam int BHT_ENTRIES = 1 << BHT_IDX_W;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;

    // Counter encoding; bit[1] is the predicted direction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    logic [1:0]           bht_q [BHT_ENTRIES];
    logic [1:0]           upd_d;
    logic [15:0]          br_cnt_q, br_cnt_d;
    logic [15:0]          mis_cnt_q, mis_cnt_d;

    logic [BHT_IDX_W-1:0] fetch_idx;
    logic [BHT_IDX_W-1:0] upd_idx;
    logic [5:0]           opcode;
    logic                 is_branch;
    logic                 is_jump;
    logic                 pred_taken;
    logic                 mispredict;
    logic [31:0]          pc4;
    logic [31:0]          br_target;
    logic [31:0]          j_target;
    logic [31:0]          pc_next;

    assign fetch_idx  = bus.pc_i[BHT_IDX_W+1:2];
    assign upd_idx    = bus.res_pc_i[BHT_IDX_W+1:2];
    assign opcode     = bus.instr_i[31:26];
    assign is_branch  = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_jump    = (opcode == OP_J);
    assign pc4        = bus.pc_i + 32'd4;
    assign br_target  = pc4 + {{14{bus.instr_i[15]}}, bus.instr_i[15:0], 2'b00};
    assign j_target   = {pc4[31:28], bus.instr_i[25:0], 2'b00};

    // Reads the pre-edge table value, so a same-cycle update is seen next cycle.
    assign pred_taken = is_branch & bht_q[fetch_idx][1];
    assign mispredict = bus.res_valid_i & (bus.res_taken_i != bus.res_pred_i);

    // Saturating increment/decrement of the counter being resolved.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        upd_d = bht_q[upd_idx];
        if (bus.res_taken_i) begin
            if (bht_q[upd_idx] != ST) upd_d = bht_q[upd_idx] + 2'd1;
        end else begin
            if (bht_q[upd_idx] != SNT) upd_d = bht_q[upd_idx] - 2'd1;
        end
    end

    // Next fetch address: reset, then redirect, then jump, then predicted branch.
    always_comb begin
        pc_next = pc4;
        if (rst_i) begin
            pc_next = RESET_VECTOR;
        end else if (mispredict) begin
            pc_next = bus.res_taken_i ? bus.res_target_i : (bus.res_pc_i + 32'd4);
        end else if (is_jump) begin
            pc_next = j_target;
        end else if (pred_taken) begin
            pc_next = br_target;
        end
    end

    // Saturating statistics: correct-path, non-stalled branch fetches and mispredicts.
    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (is_branch && bus.pc_write_i && !mispredict && (br_cnt_q != 16'hFFFF))
            br_cnt_d = br_cnt_q + 16'd1;
        if (mispredict && (mis_cnt_q != 16'hFFFF))
            mis_cnt_d = mis_cnt_q + 16'd1;
    end

    // Table and statistics registers; reset wins over a concurrent resolve.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst_i) begin
            // NOTE: the table is a small flop array, not a RAM, so every entry is reset explicitly to WNT.
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= WNT;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (bus.res_valid_i) bht_q[upd_idx] <= upd_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign bus.pc_next_o    = pc_next;
    assign bus.pred_taken_o = pred_taken;
    assign bus.flush_o      = mispredict & ~rst_i;
    assign bus.br_cnt_o     = br_cnt_q;
    assign bus.mis_cnt_o    = mis_cnt_q;
endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: directed vector table, hand-written multi-cycle
// sequences and randomized traffic compared against a behavioural model.
module tb_next_pc_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    next_pc_unit_if bus_if ();

    next_pc_unit #(
        .BHT_IDX_W   (4),
        .RESET_VECTOR(32'h0000_0000)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus_if)
    );

    localparam logic [31:0] ADD      = 32'h0000_0020;
    localparam logic [31:0] BEQ_BACK = 32'h1000_FFFE;  // beq, imm -2
    localparam logic [31:0] BNE_FWD  = 32'h1400_0003;  // bne, imm +3
    localparam logic [31:0] J_3000   = 32'h0800_0C00;  // j 0x3000 from region 0

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pw;
        logic        rv;
        logic [31:0] rpc;
        logic        rt;
        logic [31:0] rtgt;
        logic        rp;
        logic [31:0] exp_next;
        logic        exp_pred;
        logic        exp_flush;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: counter values 0..3 per entry, plain integer stats.
    int m_bht [16];
    int m_br;
    int m_mis;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic pw,
                         input logic rv, input logic [31:0] rpc, input logic rt,
                         input logic [31:0] rtgt, input logic rp);
        bus_if.pc_i         = pc;
        bus_if.instr_i      = instr;
        bus_if.pc_write_i   = pw;
        bus_if.res_valid_i  = rv;
        bus_if.res_pc_i     = rpc;
        bus_if.res_taken_i  = rt;
        bus_if.res_target_i = rtgt;
        bus_if.res_pred_i   = rp;
    endtask

    function automatic bit m_is_branch();
        int op = int'(bus_if.instr_i >> 26);
        return (op == 4) || (op == 5);
    endfunction

    function automatic bit m_is_jump();
        return int'(bus_if.instr_i >> 26) == 2;
    endfunction

    function automatic bit m_misp();
        return bus_if.res_valid_i && (bus_if.res_taken_i != bus_if.res_pred_i);
    endfunction

    function automatic bit m_pred();
        return m_is_branch() && (m_bht[(bus_if.pc_i >> 2) % 16] >= 2);
    endfunction

    function automatic logic [31:0] m_next();
        logic [31:0] pc4 = bus_if.pc_i + 32'd4;
        int off = int'($signed(bus_if.instr_i[15:0])) * 4;
        if (rst) return 32'h0;
        if (m_misp()) return bus_if.res_taken_i ? bus_if.res_target_i : bus_if.res_pc_i + 32'd4;
        if (m_is_jump()) return (pc4 & 32'hF000_0000) | ((bus_if.instr_i & 32'h03FF_FFFF) << 2);
        if (m_pred()) return pc4 + off;
        return pc4;
    endfunction

    // Model the effect of the coming clock edge from the current inputs.
    task automatic m_clock();
        if (rst) begin
            for (int i = 0; i < 16; i++) m_bht[i] = 1;
            m_br  = 0;
            m_mis = 0;
        end else begin
            if (m_is_branch() && bus_if.pc_write_i && !m_misp() && m_br < 65535) m_br++;
            if (m_misp() && m_mis < 65535) m_mis++;
            if (bus_if.res_valid_i) begin
                int idx = (bus_if.res_pc_i >> 2) % 16;
                if (bus_if.res_taken_i) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
                else                    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
            end
        end
    endtask

    task automatic tick();
        m_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model_comb(input string tag, input bit with_pred);
        check({tag, ".next"},  bus_if.pc_next_o, m_next());
        check({tag, ".flush"}, 32'(bus_if.flush_o), 32'(m_misp() && !rst));
        if (with_pred) check({tag, ".pred"}, 32'(bus_if.pred_taken_o), 32'(m_pred()));
    endtask

    task automatic check_model_cnt(input string tag);
        check({tag, ".br_cnt"},  32'(bus_if.br_cnt_o),  32'(m_br));
        check({tag, ".mis_cnt"}, 32'(bus_if.mis_cnt_o), 32'(m_mis));
    endtask

    vec_t vecs [19];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, r2, pc, rpc, instr;
        logic        rv, rt, rp, pw;
        int          br_hold;

        // pc, instr, pw, rv, rpc, rt, rtgt, rp, exp_next, exp_pred, exp_flush
        vecs[0]  = '{32'h40,  ADD,      1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h44,   1'b0, 1'b0};
        vecs[1]  = '{32'h100, BEQ_BACK, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h104,  1'b0, 1'b0};
        vecs[2]  = '{32'h104, ADD,      1'b1, 1'b1, 32'h100, 1'b1, 32'hFC, 1'b0, 32'hFC,   1'b0, 1'b1};
        vecs[3]  = '{32'h100, BEQ_BACK, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'hFC,   1'b1, 1'b0};
        vecs[4]  = '{32'hFC,  ADD,      1'b1, 1'b1, 32'h100, 1'b1, 32'hFC, 1'b1, 32'h100,  1'b0, 1'b0};
        vecs[5]  = '{32'h300, ADD,      1'b1, 1'b1, 32'h100, 1'b0, 32'hFC, 1'b1, 32'h104,  1'b0, 1'b1};
        vecs[6]  = '{32'h300, ADD,      1'b1, 1'b1, 32'h100, 1'b0, 32'hFC, 1'b1, 32'h104,  1'b0, 1'b1};
        vecs[7]  = '{32'h300, ADD,      1'b1, 1'b1, 32'h100, 1'b0, 32'hFC, 1'b0, 32'h304,  1'b0, 1'b0};
        vecs[8]  = '{32'h300, ADD,      1'b1, 1'b1, 32'h100, 1'b0, 32'hFC, 1'b0, 32'h304,  1'b0, 1'b0};
        vecs[9]  = '{32'h300, ADD,      1'b1, 1'b1, 32'h100, 1'b0, 32'hFC, 1'b0, 32'h304,  1'b0, 1'b0};
        vecs[10] = '{32'h100, BEQ_BACK, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h104,  1'b0, 1'b0};
        vecs[11] = '{32'h200, J_3000,   1'b1, 1'b1, 32'h180, 1'b0, 32'h0,  1'b1, 32'h184,  1'b0, 1'b1};
        vecs[12] = '{32'h200, J_3000,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h3000, 1'b0, 1'b0};
        vecs[13] = '{32'h40,  ADD,      1'b1, 1'b1, 32'h100, 1'b1, 32'hFC, 1'b0, 32'hFC,   1'b0, 1'b1};
        vecs[14] = '{32'h100, BEQ_BACK, 1'b1, 1'b1, 32'h100, 1'b1, 32'hFC, 1'b0, 32'hFC,   1'b0, 1'b1};
        vecs[15] = '{32'h100, BEQ_BACK, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'hFC,   1'b1, 1'b0};
        vecs[16] = '{32'h48,  BNE_FWD,  1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h4C,   1'b0, 1'b0};
        vecs[17] = '{32'h0,   ADD,      1'b1, 1'b1, 32'h48,  1'b1, 32'h58, 1'b0, 32'h58,   1'b0, 1'b1};
        vecs[18] = '{32'h48,  BNE_FWD,  1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h58,   1'b1, 1'b0};

        // Reset for two cycles with a mispredict on the resolve bus: flush must stay low.
        rst = 1'b1;
        drive(32'h40, ADD, 1'b1, 1'b1, 32'h100, 1'b1, 32'h500, 1'b0);
        #1;
        check("rst0.next",  bus_if.pc_next_o, 32'h0);
        check("rst0.flush", 32'(bus_if.flush_o), 32'h0);
        tick();
        check("rst1.next",  bus_if.pc_next_o, 32'h0);
        check("rst1.flush", 32'(bus_if.flush_o), 32'h0);
        tick();
        check("rst.br_cnt",  32'(bus_if.br_cnt_o),  32'h0);
        check("rst.mis_cnt", 32'(bus_if.mis_cnt_o), 32'h0);
        rst = 1'b0;

        // Directed vector table.
        foreach (vecs[i]) begin
            drive(vecs[i].pc, vecs[i].instr, vecs[i].pw, vecs[i].rv, vecs[i].rpc,
                  vecs[i].rt, vecs[i].rtgt, vecs[i].rp);
            #1;
            check($sformatf("vec%0d.next", i),  bus_if.pc_next_o, vecs[i].exp_next);
            check($sformatf("vec%0d.pred", i),  32'(bus_if.pred_taken_o), 32'(vecs[i].exp_pred));
            check($sformatf("vec%0d.flush", i), 32'(bus_if.flush_o), 32'(vecs[i].exp_flush));
            tick();
            check_model_cnt($sformatf("vec%0d", i));
        end

        // Stall: a branch held at fetch for three cycles is not counted.
        br_hold = m_br;
        for (int i = 0; i < 3; i++) begin
            drive(32'h100, BEQ_BACK, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            #1;
            check_model_comb($sformatf("stall%0d", i), 1'b1);
            tick();
            check($sformatf("stall%0d.br_cnt", i), 32'(bus_if.br_cnt_o), 32'(br_hold));
        end

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            r   = $urandom;
            r2  = $urandom;
            pc  = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC) : {24'h0, r2[7:2], 2'b00};
            rpc = {24'h0, r2[15:10], 2'b00};
            case ($urandom_range(0, 4))
                0:       instr = {6'b000100, r[25:0]};
                1:       instr = {6'b000101, r[25:0]};
                2:       instr = {6'b000010, r[25:0]};
                3:       instr = {6'b000000, r[25:0]};
                default: instr = r;
            endcase
            rv  = ($urandom_range(0, 2) != 0);
            rt  = 1'($urandom_range(0, 1));
            rp  = 1'($urandom_range(0, 1));
            pw  = ($urandom_range(0, 3) != 0) || (rv && (rt != rp));
            rst = ($urandom_range(0, 31) == 0);
            drive(pc, instr, pw, rv, rpc, rt, $urandom & 32'hFFFF_FFFC, rp);
            #1;
            check_model_comb($sformatf("rnd%0d", i), 1'b1);
            tick();
            check_model_cnt($sformatf("rnd%0d", i));
        end
        rst = 1'b0;

        // Reset with a concurrent not-taken resolve: the update must be discarded.
        rst = 1'b1;
        drive(32'h0, ADD, 1'b1, 1'b1, 32'h108, 1'b0, 32'h0, 1'b0);
        tick();
        rst = 1'b0;
        check("midrst.br_cnt",  32'(bus_if.br_cnt_o),  32'h0);
        check("midrst.mis_cnt", 32'(bus_if.mis_cnt_o), 32'h0);
        drive(32'h0, ADD, 1'b1, 1'b1, 32'h108, 1'b1, 32'h104, 1'b0);
        tick();
        drive(32'h108, BEQ_BACK, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check("midrst.pred", 32'(bus_if.pred_taken_o), 32'h1);
        check("midrst.next", bus_if.pc_next_o, 32'h104);
        tick();

        // Mispredict counter saturation from zero.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(32'h40, ADD, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
        for (int i = 0; i < 65534; i++) tick();
        check("sat.mis_cnt_fffe", 32'(bus_if.mis_cnt_o), 32'h0000_FFFE);
        tick();
        check("sat.mis_cnt_ffff", 32'(bus_if.mis_cnt_o), 32'h0000_FFFF);
        tick();
        tick();
        check("sat.mis_cnt_hold", 32'(bus_if.mis_cnt_o), 32'h0000_FFFF);
        check_model_cnt("sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Computes the next fetch address each cycle and drives the program counter's next-PC input.
- Decodes the fetched instruction for beq/bne/j and predicts conditional branches with a direct-mapped table of 2-bit saturating counters.
- Redirects fetch when EX reports a resolved branch whose direction was mispredicted.
- Keeps saturating statistics counters for branches fetched and mispredictions.

Parameters:
- BHT_IDX_W, 4: index width; the table holds 2^BHT_IDX_W two-bit counters.
- RESET_VECTOR, 32'h0000_0000: value of pc_next_o while reset is asserted.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- pc_i  input  32  current PC, taken from the program counter output.
- instr_i  input  32  instruction fetched at pc_i (MIPS encoding).
- pc_write_i  input  1  fetch-advance enable, the same signal that gates the PC write; 0 = stall.
- res_valid_i  input  1  EX stage resolving a beq/bne this cycle.
- res_pc_i  input  32  PC of the resolving branch.
- res_taken_i  input  1  actual branch outcome.
- res_target_i  input  32  computed taken target of the resolving branch.
- res_pred_i  input  1  pred_taken_o value carried down the pipeline with that branch.
- pc_next_o  output  32  next fetch address, fed to the program counter input.
- pred_taken_o  output  1  prediction for the instruction at pc_i; 0 when it is not beq/bne.
- flush_o  output  1  mispredict; IF/ID and ID/EX must be flushed this cycle.
- br_cnt_o  output  16  beq/bne instructions fetched, saturating.
- mis_cnt_o  output  16  mispredictions, saturating.

Behaviour:
- pc4 = pc_i + 4, modulo 2^32.
- Instruction decode:
  - Branch: opcode instr_i[31:26] is 6'b000100 or 6'b000101.
  - Branch target: pc4 + (sign-extended instr_i[15:0] << 2), modulo 2^32.
  - Jump: opcode 6'b000010; target {pc4[31:28], instr_i[25:0], 2'b00}.
- Table lookup:
  - Fetch index: pc_i[BHT_IDX_W+1:2].
  - Update index: res_pc_i[BHT_IDX_W+1:2].
  - Counter states: 00 SNT, 01 WNT, 10 WT, 11 ST; counter bit[1] is the predicted direction.
- pred_taken_o = branch & bht[fetch index][1]. It is combinational and reads the pre-edge table value.
- mispredict = res_valid_i & (res_taken_i != res_pred_i).
- flush_o = mispredict & ~rst_i. It is combinational, with zero-cycle latency.
- pc_next_o priority, combinational:
  1. rst_i: RESET_VECTOR.
  2. mispredict: res_taken_i ? res_target_i : res_pc_i + 4.
  3. jump: jump target.
  4. pred_taken_o: branch target.
  5. Otherwise: pc4.
- pc_next_o is computed regardless of pc_write_i; the program counter ignores it during a stall. A mispredict during a stall must still redirect, so the pipeline asserts pc_write_i whenever flush_o is 1.
- Table update on the rising edge when res_valid_i=1, independent of pc_write_i:
  - Taken: counter +1, saturating at 11.
  - Not taken: counter -1, saturating at 00.
- Read/write collision: fetch index equal to update index in the same cycle returns the old value; the new value is visible from the next cycle.
- br_cnt_o increments on the edge when branch & pc_write_i & ~mispredict. Wrong-path fetches and stalled repeats are not counted. It holds at 16'hFFFF.
- mis_cnt_o increments on the edge when mispredict=1. It holds at 16'hFFFF.
- Synchronous reset:
  - Every table entry is set to 01 (WNT).
  - br_cnt_o and mis_cnt_o are set to 0.
  - pred_taken_o reflects the reset table on the cycle after reset.
  - Reset mid-operation discards any in-flight update in that cycle: the reset value wins over a concurrent res_valid_i.
- No other state. Any combinational path from res_* to pc_next_o is acceptable; no registered delay is allowed.

Test Plan:
- Reset, no branch: rst_i=1 for 2 cycles -> pc_next_o=0, flush_o=0, counters 0. Release, pc_i=0x40, instr_i=add -> pc_next_o=0x44, pred_taken_o=0.
- Cold branch: pc_i=0x100, instr_i=beq with imm=0xFFFE -> pred_taken_o=0, pc_next_o=0x104, br_cnt_o increments next edge.
- Training: resolve 0x100 taken with res_pred_i=0, twice.
  - First resolve -> flush_o=1, pc_next_o=res_target_i, mis_cnt_o=1; entry becomes 10.
  - Refetch 0x100 -> pred_taken_o=1, pc_next_o=0x0FC.
  - Second resolve (res_pred_i=1) -> no flush; entry becomes 11.
- Saturation/decay: five not-taken resolves at 0x100 -> entry reaches 00 and stays; the flush on the first two is correct-by-encoding when res_pred_i=1.
- Priority and collision:
  - Jump instr at 0x200 (target 0x3000) while a mispredict resolves with res_taken_i=0, res_pc_i=0x180 -> pc_next_o=0x184.
  - Same-index fetch and update in one cycle -> old prediction is used.
- Stall and saturation:
  - pc_write_i=0 with a branch fetched for 3 cycles -> br_cnt_o unchanged.
  - Preload by forcing 65535 mispredicts -> mis_cnt_o holds 0xFFFF.
